// File: rtl/sha_round_stage_pkg.sv
// Shared SHA-256 definitions for the round and schedule stages: word and
// array widths, the round constant table K, and the round/schedule functions.
package sha_round_stage_pkg;

  localparam int WORD_S   = 32;
  localparam int W_BLKCNT = 16;
  localparam int WARR_S   = WORD_S * W_BLKCNT;
  localparam int STATE_S  = 256;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_word(input logic [5:0] idx);
    return K_TAB[idx];
  endfunction

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Message-schedule sigmas (used by the schedule stage).
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Round functions.
  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

endpackage

// File: rtl/sha_round_stage_if.sv
// Handshake/data bundle between a schedule stage and a round stage.
//   en        start strobe, state_in/W_in valid with it
//   state_in  working state {a..h}, a in [255:224]
//   W_in      16-word window, word 0 oldest at [31:0]
//   state_out state after the stage's rounds
//   W_out     window captured at start
//   en_next   one-cycle done strobe
//   busy      rounds in progress
interface sha_round_stage_if;
  import sha_round_stage_pkg::*;

  logic               en;
  logic [STATE_S-1:0] state_in;
  logic [WARR_S-1:0]  W_in;
  logic [STATE_S-1:0] state_out;
  logic [WARR_S-1:0]  W_out;
  logic               en_next;
  logic               busy;

  modport master (output en, state_in, W_in, input state_out, W_out, en_next, busy);
  modport slave  (input en, state_in, W_in, output state_out, W_out, en_next, busy);
endinterface

// File: rtl/sha_round.sv
// Combinational single SHA-256 round.
//   state_in  {a..h} before the round
//   w, k      message word and round constant
//   state_out {a..h} after the round
module sha_round
  import sha_round_stage_pkg::*;
(
  input  logic [STATE_S-1:0] state_in,
  input  logic [WORD_S-1:0]  w,
  input  logic [WORD_S-1:0]  k,
  output logic [STATE_S-1:0] state_out
);
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_in;
  assign t1 = h + big_sig1(e) + ch(e, f, g) + k + w;
  assign t2 = big_sig0(a) + maj(a, b, c);
  assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};
endmodule

// File: rtl/sha_round_stage.sv
// SHA-256 compression stage: runs DELAY rounds (global indices
// ROUND_BASE..ROUND_BASE+DELAY-1) on the working state, one round per clock,
// using a single reused sha_round instance.
//   clk, reset  clock, synchronous active-high reset
//   bus         slave side of sha_round_stage_if (en/state_in/W_in in,
//               state_out/W_out/en_next/busy out)
module sha_round_stage
  import sha_round_stage_pkg::*;
#(
  parameter int DELAY      = 8,
  parameter int ROUND_BASE = 0
) (
  input  logic             clk,
  input  logic             reset,
  sha_round_stage_if.slave bus
);
  localparam logic [3:0] LAST = 4'(DELAY - 1);

  logic [STATE_S-1:0] state_r;
  logic [STATE_S-1:0] state_nx;
  logic [WARR_S-1:0]  w_r;
  logic               busy_r;
  logic               en_next_r;
  logic [3:0]         cnt;
  logic [31:0]        w_word;
  logic [5:0]         k_idx;

  assign w_word = w_r[{cnt, 5'b0} +: 32];
  assign k_idx  = 6'(ROUND_BASE) + {2'b00, cnt};

  sha_round u_round (
    .state_in  (state_r),
    .w         (w_word),
    .k         (k_word(k_idx)),
    .state_out (state_nx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= '0;
      w_r       <= '0;
      busy_r    <= 1'b0;
      en_next_r <= 1'b0;
      cnt       <= '0;
    end else begin
      en_next_r <= 1'b0;
      if (busy_r) begin
        state_r <= state_nx;
        if (cnt == LAST) begin
          busy_r    <= 1'b0;
          cnt       <= '0;
          en_next_r <= 1'b1;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else if (bus.en) begin
        state_r <= bus.state_in;
        w_r     <= bus.W_in;
        busy_r  <= 1'b1;
        cnt     <= '0;
      end
    end
  end

  assign bus.state_out = state_r;
  assign bus.W_out     = w_r;
  assign bus.busy      = busy_r;
  assign bus.en_next   = en_next_r;
endmodule
